// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - programmable prescaler timebase with one-shot/periodic delay counter
//
// Purpose:
//   A synchronous prescaler produces a one-cycle tick every (prescale+1) enabled
//   cycles and a square wave q_out that toggles on each tick. A delay counter
//   counts ticks down from delay_len and pulses done on expiry. It can run as a
//   one-shot, or as a periodic timer that reloads on each expiry.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   enable     in   advances prescaler and delay counter; both freeze when low
//   prescale   in   [WIDTH]  tick period minus one
//   mode       in   0 = one-shot, 1 = periodic (auto-reload)
//   delay_len  in   [CNT_W]  delay length in ticks (sampled on start and reload)
//   start      in   load and run a delay (restarts if already running)
//   abort      in   cancel the delay, no done
//   tick       out  one-cycle pulse per prescaler wrap
//   q_out      out  toggles on every tick
//   busy       out  delay running
//   done       out  one-cycle pulse on expiry
//   remaining  out  [CNT_W]  ticks left in the current delay

module delay_timer #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] prescale,
    input  logic             mode,
    input  logic [CNT_W-1:0] delay_len,
    input  logic             start,
    input  logic             abort,
    output logic             tick,
    output logic             q_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pre_cnt;
    logic [WIDTH-1:0] w_pre_cnt_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_q;
    logic             w_q_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic [CNT_W-1:0] r_rem;
    logic [CNT_W-1:0] w_rem_nxt;
    logic             w_wrap;
    logic             w_len_zero;
    logic             w_clr_pre;

    // The >= compare lets a prescale lowered below the current count wrap at once
    // instead of running all the way around the counter.
    assign w_wrap     = enable & (r_pre_cnt >= prescale);
    assign w_len_zero = (delay_len == '0);

    // Prescaler next state
    always_comb begin
        w_pre_cnt_nxt = r_pre_cnt;
        w_tick_nxt    = 1'b0;
        w_q_nxt       = r_q;
        if (w_wrap) begin
            w_pre_cnt_nxt = '0;
            w_tick_nxt    = 1'b1;
            w_q_nxt       = ~r_q;
        end else if (enable) begin
            w_pre_cnt_nxt = r_pre_cnt + WIDTH'(1);
        end
    end

    // Delay FSM next state; priority abort > start > expiry/decrement
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        w_clr_pre   = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
            w_rem_nxt   = '0;
        end else if (start) begin
            if (w_len_zero) begin
                // Zero-length request: immediate done from IDLE; a running
                // delay is simply stopped, since a restart never issues done.
                w_done_nxt  = (r_state == S_IDLE);
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
            end else begin
                // Clearing the prescaler aligns the first tick exactly
                // prescale+1 cycles after start, so delays are exact.
                w_state_nxt = S_RUN;
                w_rem_nxt   = delay_len;
                w_clr_pre   = 1'b1;
            end
        end else if (r_state == S_RUN && w_wrap) begin
            if (r_rem > CNT_W'(1)) begin
                w_rem_nxt = r_rem - CNT_W'(1);
            end else begin
                w_done_nxt = 1'b1;
                if (mode && !w_len_zero) begin
                    w_rem_nxt = delay_len;
                end else begin
                    w_rem_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pre_cnt <= '0;
            r_tick    <= 1'b0;
            r_q       <= 1'b0;
            r_done    <= 1'b0;
            r_rem     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre_cnt <= w_clr_pre ? '0 : w_pre_cnt_nxt;
            r_tick    <= w_tick_nxt;
            r_q       <= w_q_nxt;
            r_done    <= w_done_nxt;
            r_rem     <= w_rem_nxt;
        end
    end

    assign tick      = r_tick;
    assign q_out     = r_q;
    assign busy      = (r_state == S_RUN);
    assign done      = r_done;
    assign remaining = r_rem;

endmodule

// File: tb/tb_delay_timer.sv
// tb/tb_delay_timer.sv - self-checking bench for delay_timer

module tb_delay_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [9:0]  prescale = '0;
    logic        mode = 1'b0;
    logic [15:0] delay_len = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        tick;
    logic        q_out;
    logic        busy;
    logic        done;
    logic [15:0] remaining;

    int n_chk = 0;
    int n_err = 0;

    // reference model: "running" is simply "ticks left is nonzero"
    int m_pre = 0;
    int m_rem = 0;
    bit m_q = 0;
    bit m_tick = 0;
    bit m_done = 0;

    typedef struct {
        logic        rst, en;
        logic [9:0]  p;
        logic        mode;
        logic [15:0] len;
        logic        st, ab;
        logic        tick, q, busy, done;
        logic [15:0] rem;
    } vec_t;

    vec_t tv[15];

    delay_timer #(.WIDTH(10), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .mode(mode),
        .delay_len(delay_len), .start(start), .abort(abort), .tick(tick),
        .q_out(q_out), .busy(busy), .done(done), .remaining(remaining)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit wrap;
        if (rst) begin
            m_pre = 0; m_q = 0; m_tick = 0; m_done = 0; m_rem = 0;
        end else begin
            wrap   = enable && (m_pre >= int'(prescale));
            m_tick = wrap;
            m_done = 0;
            if (wrap) begin
                m_pre = 0;
                m_q   = !m_q;
            end else if (enable) begin
                m_pre = m_pre + 1;
            end
            if (abort) begin
                m_rem = 0;
            end else if (start) begin
                if (delay_len == 0) begin
                    m_done = (m_rem == 0);
                    m_rem  = 0;
                end else begin
                    m_rem = int'(delay_len);
                    m_pre = 0;
                end
            end else if (m_rem != 0 && wrap) begin
                if (m_rem == 1) begin
                    m_done = 1;
                    m_rem  = mode ? int'(delay_len) : 0;
                end else begin
                    m_rem = m_rem - 1;
                end
            end
        end
    endtask

    // one clock: model follows the inputs seen at the edge, outputs sampled 1 ns later
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // P=3, L=5 one-shot; stop_at>0 asserts rst after that many cycles past start
    task automatic one_shot(input int stop_at);
        enable = 1'b1; prescale = 10'd3; delay_len = 16'd5; mode = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("os_busy_start", busy, 1);
        chk("os_rem_start", remaining, 5);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == stop_at) begin
                chk("mid_rem", remaining, 2);
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk("mid_outs", {tick, q_out, busy, done, remaining}, 0);
                return;
            end
            chk("os_rem", remaining, (i < 20) ? 5 - i / 4 : 0);
            chk("os_done", done, i == 20);
            chk("os_busy", busy, i < 20);
            chk("os_tick", tick, (i % 4) == 0);
        end
        step();
        chk("os_done_once", done, 0);
    endtask

    initial begin
        int first_t, last_t, nt, bad_t, first_q, last_q, nq, bad_q;
        logic qp;

        //                rst en  p   md len st ab  tk q  bsy dn rem
        tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 0, 2, 1, 0, 1, 1, 1, 0, 2};
        tv[2]  = '{0, 1, 0, 0, 2, 0, 0, 1, 0, 1, 0, 1};
        tv[3]  = '{0, 1, 0, 0, 2, 0, 0, 1, 1, 0, 1, 0};
        tv[4]  = '{0, 1, 0, 0, 2, 0, 1, 1, 0, 0, 0, 0};
        tv[5]  = '{0, 1, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0};
        tv[6]  = '{0, 0, 0, 0, 3, 1, 0, 0, 1, 1, 0, 3};
        tv[7]  = '{0, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0, 3};
        tv[8]  = '{0, 1, 0, 0, 3, 1, 1, 1, 0, 0, 0, 0};
        tv[9]  = '{0, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1};
        tv[10] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1};
        tv[11] = '{0, 1, 0, 1, 2, 1, 0, 1, 1, 1, 0, 2};
        tv[12] = '{0, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1};
        tv[13] = '{0, 1, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0};
        tv[14] = '{1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            rst = tv[i].rst; enable = tv[i].en; prescale = tv[i].p; mode = tv[i].mode;
            delay_len = tv[i].len; start = tv[i].st; abort = tv[i].ab;
            step();
            chk($sformatf("vec%0d", i), {tick, q_out, busy, done, remaining},
                {tv[i].tick, tv[i].q, tv[i].busy, tv[i].done, tv[i].rem});
        end
        start = 1'b0; abort = 1'b0; mode = 1'b0;

        // divider equivalence, P=511
        do_reset();
        enable = 1'b1; prescale = 10'd511;
        first_t = 0; last_t = 0; nt = 0; bad_t = 0;
        first_q = 0; last_q = 0; nq = 0; bad_q = 0; qp = 1'b0;
        for (int c = 1; c <= 4096; c++) begin
            step();
            if (tick) begin
                if (nt == 0) first_t = c; else if (c - last_t != 512) bad_t++;
                last_t = c; nt++;
            end
            if (q_out && !qp) begin
                if (nq == 0) first_q = c; else if (c - last_q != 1024) bad_q++;
                last_q = c; nq++;
            end
            qp = q_out;
        end
        chk("div_first_tick", first_t, 512);
        chk("div_tick_count", nt, 8);
        chk("div_tick_gaps", bad_t, 0);
        chk("div_q_rises", nq, 4);
        chk("div_q_gaps", bad_q, 0);

        // one-shot, then reset mid-delay and a fresh one-shot
        do_reset();
        for (int i = 0; i < 9; i++) step();
        one_shot(0);
        one_shot(12);
        one_shot(0);

        // periodic, P=0 L=3, two enable-low cycles inside the first delay
        prescale = 10'd0; delay_len = 16'd3; mode = 1'b1; enable = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            enable = !(i == 2 || i == 3);
            step();
            chk("per_done", done, (i >= 5) && ((i - 5) % 3 == 0));
            chk("per_busy", busy, 1);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("per_abort", {busy, done, remaining}, 0);
        mode = 1'b0;

        // dynamic prescale: count reaches 9 under P=15, then P drops to 4
        do_reset();
        enable = 1'b1; prescale = 10'd15;
        for (int i = 0; i < 9; i++) begin
            step();
            chk("dyn_no_tick", tick, 0);
        end
        prescale = 10'd4;
        step();
        chk("dyn_wrap_now", tick, 1);
        for (int i = 1; i <= 15; i++) begin
            step();
            chk("dyn_tick", tick, (i % 5) == 0);
        end

        // randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 399) == 0);
            enable    = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 49) == 0) prescale = 10'($urandom_range(0, 6));
            mode      = 1'($urandom_range(0, 1));
            delay_len = 16'($urandom_range(0, 6));
            start     = ($urandom_range(0, 19) == 0);
            abort     = ($urandom_range(0, 39) == 0);
            step();
            chk("rand", {tick, q_out, busy, done, remaining},
                {m_tick, m_q, m_rem != 0, m_done, 16'(m_rem)});
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
